// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core with a single req/ready memory port.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Any
// bus phase may be stretched by the memory holding mem_ready low.
module cpu_multicycle #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            halt,
    output logic [XLEN-1:0] pc_out
);
    localparam int RIDX = $clog2(NREGS);
    localparam int SHW  = $clog2(XLEN);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   pc_reg;
    logic [31:0]       ir_reg;
    logic [XLEN-1:0]   a_reg, b_reg, imm_reg, alu_reg, mdr_reg;
    logic [XLEN-1:0]   regs [NREGS];

    // Instruction fields; the instruction register is stable after FETCH.
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd_field;
    logic [RIDX-1:0] rs1_idx, rs2_idx, rd_idx;
    logic            is_op, is_opimm, is_lw, is_sw, is_br;
    logic            legal, rd_bad, illegal;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;

    assign opcode   = ir_reg[6:0];
    assign funct3   = ir_reg[14:12];
    assign funct7   = ir_reg[31:25];
    assign rd_field = ir_reg[11:7];
    assign rs1_idx  = ir_reg[15 +: RIDX];
    assign rs2_idx  = ir_reg[20 +: RIDX];
    assign rd_idx   = ir_reg[7 +: RIDX];
    assign is_op    = (opcode == OPC_OP);
    assign is_opimm = (opcode == OPC_OPIMM);
    assign is_lw    = (opcode == OPC_LOAD);
    assign is_sw    = (opcode == OPC_STORE);
    assign is_br    = (opcode == OPC_BRANCH);
    assign imm_i    = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:20]};
    assign imm_s    = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
    assign imm_b    = {{(XLEN-13){ir_reg[31]}}, ir_reg[31], ir_reg[7],
                       ir_reg[30:25], ir_reg[11:8], 1'b0};

    // Legality: opcode plus the funct3/funct7 combinations this core implements.
    always_comb begin
        legal = 1'b0;
        if (is_op) begin
            if (funct3 == 3'b000 || funct3 == 3'b101)
                legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            else
                legal = (funct7 == 7'h00) && (funct3 != 3'b011);
        end else if (is_opimm) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                    (funct3 == 3'b100) || (funct3 == 3'b010);
        end else if (is_lw || is_sw) begin
            legal = (funct3 == 3'b010);
        end else if (is_br) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        end
    end

    // A destination beyond the implemented register file stops the core.
    assign rd_bad  = (is_op || is_opimm || is_lw) && ({27'd0, rd_field} >= 32'(NREGS));
    assign illegal = !legal || rd_bad;

    // ALU and branch comparison, evaluated in EXEC from the latched operands.
    logic [XLEN-1:0] op2, alu_res;
    logic [SHW-1:0]  shamt;
    logic            taken;
    assign op2   = is_op ? b_reg : imm_reg;
    assign shamt = op2[SHW-1:0];
    assign taken = (funct3 == 3'b000) ? (a_reg == b_reg) : (a_reg != b_reg);

    always_comb begin
        alu_res = a_reg + op2;
        if (is_op || is_opimm) begin
            case (funct3)
                3'b000:  alu_res = (is_op && funct7[5]) ? (a_reg - op2) : (a_reg + op2);
                3'b111:  alu_res = a_reg & op2;
                3'b110:  alu_res = a_reg | op2;
                3'b100:  alu_res = a_reg ^ op2;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_reg) < $signed(op2))};
                3'b001:  alu_res = a_reg << shamt;
                3'b101:  alu_res = funct7[5] ? XLEN'($signed(a_reg) >>> shamt)
                                             : (a_reg >> shamt);
                default: alu_res = a_reg + op2;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_FETCH;
        else     state_reg <= state_next;
    end

    // Next-state sequencing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = illegal ? S_HALT : S_EXEC;
            S_EXEC:   state_next = is_br ? S_FETCH : ((is_lw || is_sw) ? S_MEM : S_WB);
            S_MEM:    if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_HALT;
        endcase
    end

    // Bus and status outputs; reset suppresses any request in the same cycle.
    always_comb begin
        mem_req   = !rst && (state_reg == S_FETCH || state_reg == S_MEM);
        mem_we    = !rst && (state_reg == S_MEM) && is_sw;
        mem_addr  = (state_reg == S_MEM) ? {alu_reg[XLEN-1:2], 2'b00} : pc_reg;
        mem_wdata = b_reg;
        halt      = (state_reg == S_HALT);
        pc_out    = pc_reg;
    end

    // Datapath registers and register file, updated per FSM phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg  <= RESET_PC;
            ir_reg  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            imm_reg <= '0;
            alu_reg <= '0;
            mdr_reg <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state_reg)
                S_FETCH: if (mem_ready) ir_reg <= 32'(mem_rdata);
                S_DECODE: begin
                    a_reg   <= regs[rs1_idx];
                    b_reg   <= regs[rs2_idx];
                    imm_reg <= is_sw ? imm_s : (is_br ? imm_b : imm_i);
                end
                S_EXEC: begin
                    alu_reg <= alu_res;
                    if (is_br) pc_reg <= taken ? (pc_reg + imm_reg) : (pc_reg + XLEN'(4));
                end
                S_MEM: begin
                    if (mem_ready && is_lw) mdr_reg <= mem_rdata;
                    if (mem_ready && is_sw) pc_reg <= pc_reg + XLEN'(4);
                end
                S_WB: begin
                    if (rd_idx != '0) regs[rd_idx] <= is_lw ? mdr_reg : alu_reg;
                    pc_reg <= pc_reg + XLEN'(4);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: a program runs from a bench-side
// memory; every expected bus transfer (with its cycle gap from the previous
// transfer) is queued up front and compared as the core issues it.
module tb_cpu_multicycle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, halt;
    logic [31:0] mem_addr, mem_wdata, pc_out;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    cpu_multicycle dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .halt(halt), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          gap;
    } txn_t;

    txn_t        sbq[$];
    logic [31:0] mem [0:1023];
    int          ncmp = 0, nfail = 0, ntxn = 0;
    int          pending_gap = -1, last_start = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.waits = waits; t.gap = gap;
        sbq.push_back(t);
    endtask
    // Expected trace builders; each records the cycles the instruction costs.
    task automatic ex_op(input logic [31:0] pc);
        push(1'b0, pc, '0, 0, pending_gap); pending_gap = 4;
    endtask
    task automatic ex_br(input logic [31:0] pc);
        push(1'b0, pc, '0, 0, pending_gap); pending_gap = 3;
    endtask
    task automatic ex_sw(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        push(1'b0, pc, '0, 0, pending_gap); push(1'b1, a, d, 0, 3); pending_gap = 1;
    endtask
    task automatic ex_lw(input logic [31:0] pc, input logic [31:0] a, input int w);
        push(1'b0, pc, '0, 0, pending_gap); push(1'b0, a, '0, w, 3); pending_gap = 2 + w;
    endtask
    task automatic ex_last(input logic [31:0] pc);
        push(1'b0, pc, '0, 0, pending_gap); pending_gap = -1;
    endtask

    // Serve the next expected transfer: check it, optionally stall, then accept.
    task automatic serve();
        txn_t t;
        int   n;
        t = sbq.pop_front();
        n = 0;
        while (mem_req !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("req_timeout", {31'd0, mem_req}, 32'd1);
        if (mem_req !== 1'b1) return;
        if (t.gap >= 0) chk("cycle_gap", 32'(cyc - last_start), 32'(t.gap));
        last_start = cyc;
        chk("we", {31'd0, mem_we}, {31'd0, t.we});
        chk("addr", mem_addr, t.addr);
        if (t.we) chk("wdata", mem_wdata, t.wdata);
        for (int i = 0; i < t.waits; i++) begin
            @(posedge clk); #1;
            chk("hold_req", {31'd0, mem_req}, 32'd1);
            chk("hold_addr", mem_addr, t.addr);
        end
        mem_rdata = mem[t.addr[11:2]];
        if (mem_we === 1'b1) mem[mem_addr[11:2]] = mem_wdata;
        $display("txn %0d: we=%0d addr=%h wdata=%h rdata=%h waits=%0d cyc=%0d",
                 ntxn, mem_we, mem_addr, mem_wdata, mem_rdata, t.waits, cyc);
        ntxn++;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    task automatic check_halted();
        @(posedge clk); #1;
        chk("halt_set", {31'd0, halt}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("halt_no_req", {31'd0, mem_req}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] t_ins [15];
    logic [31:0] t_exp [15];
    logic [31:0] pc;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        // Opening program: arithmetic, store/load, branch loop, x0 handling.
        mem[0]  = enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'h13);  // ADDI x1,x0,5
        mem[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'h13);  // ADDI x2,x0,-3
        mem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);     // ADD x3,x1,x2
        mem[3]  = enc_s(12'h040, 5'd3, 5'd0);                 // SW x3,0x40(x0)
        mem[4]  = enc_i(12'h040, 5'd0, 3'b010, 5'd4, 7'h03);  // LW x4,0x40(x0)
        mem[5]  = enc_s(12'h044, 5'd4, 5'd0);                 // SW x4,0x44(x0)
        mem[6]  = enc_b(13'd16,  5'd0, 5'd6, 3'b001);         // 0x18 BNE x6,x0,+16
        mem[7]  = enc_i(12'd1,   5'd0, 3'b000, 5'd6, 7'h13);  // ADDI x6,x0,1
        mem[8]  = enc_b(13'h1FF8, 5'd1, 5'd1, 3'b000);        // 0x20 BEQ x1,x1,-8
        mem[10] = enc_b(13'd8,   5'd1, 5'd1, 3'b001);         // 0x28 BNE x1,x1,+8
        mem[11] = enc_i(12'd7,   5'd0, 3'b000, 5'd0, 7'h13);  // ADDI x0,x0,7
        mem[12] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5);     // ADD x5,x0,x0
        mem[13] = enc_s(12'h048, 5'd5, 5'd0);                 // SW x5,0x48(x0)
        mem[14] = enc_b(13'd24,  5'd0, 5'd0, 3'b000);         // 0x38 BEQ x0,x0,+24

        ex_op(32'h00); ex_op(32'h04); ex_op(32'h08);
        ex_sw(32'h0C, 32'h40, 32'd2);
        ex_lw(32'h10, 32'h40, 3);
        ex_sw(32'h14, 32'h44, 32'd2);
        ex_br(32'h18); ex_op(32'h1C); ex_br(32'h20); ex_br(32'h18);
        ex_br(32'h28); ex_op(32'h2C); ex_op(32'h30);
        ex_sw(32'h34, 32'h48, 32'd0);
        ex_br(32'h38);

        // ALU table at 0x50: each result lands in x7 and is stored to 0x200.
        t_ins[0]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd7); t_exp[0]  = 32'hFFFFFFF8; // SUB
        t_ins[1]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd7); t_exp[1]  = 32'd1;        // SLT -3<5
        t_ins[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd7); t_exp[2]  = 32'd0;        // SLT 5<-3
        t_ins[3]  = enc_r(7'h20, 5'd1, 5'd2, 3'b101, 5'd7); t_exp[3]  = 32'hFFFFFFFF; // SRA
        t_ins[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd7); t_exp[4]  = 32'h07FFFFFF; // SRL
        t_ins[5]  = enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd7); t_exp[5]  = 32'h000000A0; // SLL
        t_ins[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd7); t_exp[6]  = 32'hFFFFFFF8; // XOR
        t_ins[7]  = enc_r(7'h00, 5'd1, 5'd2, 3'b111, 5'd7); t_exp[7]  = 32'd5;        // AND
        t_ins[8]  = enc_r(7'h00, 5'd3, 5'd1, 3'b110, 5'd7); t_exp[8]  = 32'd7;        // OR
        t_ins[9]  = enc_i(12'h00F, 5'd2, 3'b111, 5'd7, 7'h13); t_exp[9]  = 32'hD;      // ANDI
        t_ins[10] = enc_i(12'h030, 5'd1, 3'b110, 5'd7, 7'h13); t_exp[10] = 32'h35;     // ORI
        t_ins[11] = enc_i(12'hFFF, 5'd1, 3'b100, 5'd7, 7'h13); t_exp[11] = 32'hFFFFFFFA; // XORI
        t_ins[12] = enc_i(12'hFFE, 5'd2, 3'b010, 5'd7, 7'h13); t_exp[12] = 32'd1;      // SLTI
        t_ins[13] = enc_i(12'd33,  5'd0, 3'b000, 5'd7, 7'h13); t_exp[13] = 32'd33;     // ADDI
        t_ins[14] = enc_r(7'h00, 5'd7, 5'd1, 3'b001, 5'd7); t_exp[14] = 32'd10;       // SLL by 33
        pc = 32'h50;
        for (int i = 0; i < 15; i++) begin
            mem[pc[11:2]] = t_ins[i];
            ex_op(pc);
            pc = pc + 4;
            mem[pc[11:2]] = enc_s(12'h200, 5'd7, 5'd0);
            ex_sw(pc, 32'h200, t_exp[i]);
            pc = pc + 4;
        end
        mem[pc[11:2]] = enc_i(12'd1, 5'd7, 3'b000, 5'd7, 7'h13);       // ADDI x7,x7,1
        ex_op(pc); pc = pc + 4;
        mem[pc[11:2]] = enc_s(12'h200, 5'd7, 5'd0);
        ex_sw(pc, 32'h200, 32'd11); pc = pc + 4;
        mem[pc[11:2]] = enc_s(12'h203, 5'd1, 5'd0);                    // misaligned SW
        ex_sw(pc, 32'h200, 32'd5); pc = pc + 4;
        mem[pc[11:2]] = 32'h0000007F;                                  // illegal opcode
        ex_last(pc);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_pc", pc_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);

        while (sbq.size() > 0) serve();
        check_halted();

        // Reset out of HALT, then reset again while a fetch is stalled.
        mem[0] = enc_s(12'h200, 5'd1, 5'd0);                           // SW x1,0x200(x0)
        mem[1] = 32'h0000007F;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_pc", pc_out, 32'h0);
        chk("rst2_halt", {31'd0, halt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("refetch_req", {31'd0, mem_req}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("stalled_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_drops_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk("rst3_req", {31'd0, mem_req}, 32'd0);
        chk("rst3_pc", pc_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pending_gap = -1;
        ex_sw(32'h0, 32'h200, 32'd0);                                  // x1 cleared by reset
        ex_last(32'h4);
        while (sbq.size() > 0) serve();
        check_halted();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
